// File: rtl/muxn_skid_pkg.sv
// Shared constants and helpers for the N-way registered selector.
// The select-error data value and the supported channel-count range live here.
package muxn_skid_pkg;

    // Data presented for a beat whose select index has no channel.
    localparam int unsigned MUXN_ERR_DATA = 0;

    // Supported channel-count range.
    localparam int unsigned MUXN_N_MIN = 2;
    localparam int unsigned MUXN_N_MAX = 16;

    // Select-field width: ceil(log2(n)), never below one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/muxn_skid_muxn.sv
// Combinational N-way channel selector with out-of-range flag.
// Channel k maps to sel == k; any sel >= N yields MUXN_ERR_DATA with err set.
module muxn
    import muxn_skid_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SW    = sel_width(N)
) (
    input  logic [N*WIDTH-1:0] din,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   out,
    output logic               err
);

    logic [WIDTH-1:0] w_ch [N];

    for (genvar k = 0; k < N; k++) begin : g_ch
        assign w_ch[k] = din[k*WIDTH +: WIDTH];
    end

    // When N fills the select space every index is valid, so no range check exists.
    if ((32'd1 << SW) == N) begin : g_full
        assign out = w_ch[sel];
        assign err = 1'b0;
    end else begin : g_range
        always_comb begin
            out = WIDTH'(MUXN_ERR_DATA);
            err = 1'b1;
            if (32'(sel) < N) begin
                out = w_ch[sel];
                err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/muxn_skid.sv
// N-way selector with a registered output stage and a 2-entry skid buffer.
// in_ready depends only on skid occupancy, so there is no ready path through the block.
module muxn_skid
    import muxn_skid_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SW    = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SW-1:0]      sel,
    input  logic [N*WIDTH-1:0] din,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   dout,
    output logic [SW-1:0]      out_sel,
    output logic               sel_err
);

    logic [WIDTH-1:0] w_mux_data;
    logic             w_mux_err;
    logic             w_accept;
    logic             w_release;
    logic             w_main_free;

    logic [WIDTH-1:0] r_main_data;
    logic [SW-1:0]    r_main_sel;
    logic             r_main_err;
    logic             r_main_valid;

    logic [WIDTH-1:0] r_skid_data;
    logic [SW-1:0]    r_skid_sel;
    logic             r_skid_err;
    logic             r_skid_valid;

    muxn #(
        .WIDTH (WIDTH),
        .N     (N),
        .SW    (SW)
    ) u_muxn (
        .din (din),
        .sel (sel),
        .out (w_mux_data),
        .err (w_mux_err)
    );

    assign w_accept    = in_valid & in_ready;
    assign w_release   = r_main_valid & out_ready;
    assign w_main_free = ~r_main_valid | w_release;

    // Main stage: refilled from skid first to keep acceptance order, else from input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_sel   <= '0;
            r_main_err   <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_data  <= r_skid_data;
                r_main_sel   <= r_skid_sel;
                r_main_err   <= r_skid_err;
            end else if (w_accept) begin
                r_main_valid <= 1'b1;
                r_main_data  <= w_mux_data;
                r_main_sel   <= sel;
                r_main_err   <= w_mux_err;
            end else begin
                r_main_valid <= 1'b0;
            end
        end
    end

    // Skid stage: catches a beat accepted while main is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_sel   <= '0;
            r_skid_err   <= 1'b0;
        end else if (flush) begin
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            r_skid_valid <= 1'b0;
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= w_mux_data;
            r_skid_sel   <= sel;
            r_skid_err   <= w_mux_err;
        end
    end

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_main_valid;
    assign dout      = r_main_data;
    assign out_sel   = r_main_sel;
    assign sel_err   = r_main_err;

endmodule

// File: tb/tb_muxn_skid.sv
// Bench for muxn_skid: directed table, hand-written corner sequences and a
// randomized run against a queue model, on an N=4 and an N=3 instance.
module tb_muxn_skid;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         fl4, iv4, ir4, ov4, or4, err4;
    logic [1:0]   sel4, osel4;
    logic [127:0] din4;
    logic [31:0]  dout4;

    logic         fl3, iv3, ir3, ov3, or3, err3;
    logic [1:0]   sel3, osel3;
    logic [95:0]  din3;
    logic [31:0]  dout3;

    muxn_skid #(.WIDTH(32), .N(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(fl4), .in_valid(iv4), .in_ready(ir4),
        .sel(sel4), .din(din4), .out_valid(ov4), .out_ready(or4),
        .dout(dout4), .out_sel(osel4), .sel_err(err4)
    );

    muxn_skid #(.WIDTH(32), .N(3)) u_dut3 (
        .clk(clk), .rst(rst), .flush(fl3), .in_valid(iv3), .in_ready(ir3),
        .sel(sel3), .din(din3), .out_valid(ov3), .out_ready(or3),
        .dout(dout3), .out_sel(osel3), .sel_err(err3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
        logic        e;
    } beat_t;

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] dout;
        logic [1:0]  osel;
        logic        ir;
    } vec_t;

    vec_t  tbl [14];
    beat_t q4 [$];
    beat_t q3 [$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic iv, input int unsigned s, input logic ordy,
                                input logic fl, input logic ov, input logic [31:0] d,
                                input int unsigned os, input logic ir);
        vec_t v;
        v.iv = iv; v.sel = 2'(s); v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.dout = d; v.osel = 2'(os); v.ir = ir;
        return v;
    endfunction

    // Reference: channel s of a packed bus, or zero with error when s has no channel.
    function automatic beat_t model_beat(input logic [127:0] d, input int unsigned s,
                                         input int unsigned n);
        beat_t b;
        b.s = 2'(s);
        if (s < n) begin
            b.d = 32'(d >> (s * 32));
            b.e = 1'b0;
        end else begin
            b.d = 32'h0;
            b.e = 1'b1;
        end
        return b;
    endfunction

    initial begin
        rst = 1'b1;
        fl4 = 0; iv4 = 0; or4 = 0; sel4 = 0; din4 = '0;
        fl3 = 0; iv3 = 0; or3 = 0; sel3 = 0; din3 = '0;

        step();
        chk("rst4 out_valid", 64'(ov4), 64'(0));
        chk("rst4 dout", 64'(dout4), 64'(0));
        chk("rst4 in_ready", 64'(ir4), 64'(1));
        chk("rst3 out_valid", 64'(ov3), 64'(0));
        chk("rst3 in_ready", 64'(ir3), 64'(1));
        rst = 1'b0;

        // Streaming, backpressure and flush vectors on the N=4 instance.
        tbl[0]  = mk(1, 0, 1, 0, 1, 32'h1000, 0, 1);
        tbl[1]  = mk(1, 1, 1, 0, 1, 32'h1001, 1, 1);
        tbl[2]  = mk(1, 2, 1, 0, 1, 32'h1002, 2, 1);
        tbl[3]  = mk(1, 3, 1, 0, 1, 32'h1003, 3, 1);
        tbl[4]  = mk(0, 0, 1, 0, 0, 32'h0,    0, 1);
        tbl[5]  = mk(1, 1, 0, 0, 1, 32'h1001, 1, 1);
        tbl[6]  = mk(1, 3, 0, 0, 1, 32'h1001, 1, 0);
        tbl[7]  = mk(1, 0, 0, 0, 1, 32'h1001, 1, 0);
        tbl[8]  = mk(0, 0, 1, 0, 1, 32'h1003, 3, 1);
        tbl[9]  = mk(0, 0, 1, 0, 0, 32'h0,    0, 1);
        tbl[10] = mk(1, 2, 0, 0, 1, 32'h1002, 2, 1);
        tbl[11] = mk(1, 0, 0, 0, 1, 32'h1002, 2, 0);
        tbl[12] = mk(1, 1, 1, 1, 0, 32'h0,    0, 1);
        tbl[13] = mk(0, 0, 1, 0, 0, 32'h0,    0, 1);

        din4 = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
        for (int i = 0; i < 14; i++) begin
            iv4 = tbl[i].iv; sel4 = tbl[i].sel; or4 = tbl[i].ordy; fl4 = tbl[i].fl;
            step();
            chk($sformatf("row%0d out_valid", i), 64'(ov4), 64'(tbl[i].ov));
            chk($sformatf("row%0d in_ready", i), 64'(ir4), 64'(tbl[i].ir));
            if (tbl[i].ov) begin
                chk($sformatf("row%0d dout", i), 64'(dout4), 64'(tbl[i].dout));
                chk($sformatf("row%0d out_sel", i), 64'(osel4), 64'(tbl[i].osel));
                chk($sformatf("row%0d sel_err", i), 64'(err4), 64'(0));
            end
        end
        iv4 = 0; fl4 = 0;

        // Async reset with both stages full.
        or4 = 0; iv4 = 1; sel4 = 1;
        step();
        sel4 = 3;
        step();
        chk("pre-rst in_ready", 64'(ir4), 64'(0));
        chk("pre-rst out_valid", 64'(ov4), 64'(1));
        din4 = {32'h1003, 32'hA5A5_0002, 32'h1001, 32'h1000};
        sel4 = 2;
        #3 rst = 1'b1;
        #1;
        chk("async rst out_valid", 64'(ov4), 64'(0));
        chk("async rst dout", 64'(dout4), 64'(0));
        chk("async rst out_sel", 64'(osel4), 64'(0));
        chk("async rst sel_err", 64'(err4), 64'(0));
        chk("async rst in_ready", 64'(ir4), 64'(1));
        step();
        chk("beat during rst ignored", 64'(ov4), 64'(0));
        rst = 1'b0;
        or4 = 1;
        step();
        chk("post-rst out_valid", 64'(ov4), 64'(1));
        chk("post-rst dout", 64'(dout4), 64'(32'hA5A5_0002));
        chk("post-rst out_sel", 64'(osel4), 64'(2));
        iv4 = 0;
        step();
        chk("post-rst drained", 64'(ov4), 64'(0));

        // Out-of-range select on the N=3 instance.
        din3 = {32'h3002, 32'h3001, 32'h3000};
        iv3 = 1; sel3 = 3; or3 = 1;
        step();
        chk("oor out_valid", 64'(ov3), 64'(1));
        chk("oor dout", 64'(dout3), 64'(0));
        chk("oor sel_err", 64'(err3), 64'(1));
        chk("oor out_sel", 64'(osel3), 64'(3));
        sel3 = 0;
        step();
        chk("inrange dout", 64'(dout3), 64'(32'h3000));
        chk("inrange sel_err", 64'(err3), 64'(0));
        chk("inrange out_sel", 64'(osel3), 64'(0));
        iv3 = 0;
        step();
        chk("n3 drained", 64'(ov3), 64'(0));

        // Randomized traffic against a FIFO-of-two model on both instances.
        for (int c = 0; c < 10000; c++) begin
            chk("rnd4 out_valid", 64'(ov4), 64'(q4.size() > 0));
            chk("rnd4 in_ready", 64'(ir4), 64'(q4.size() < 2));
            if (q4.size() > 0) begin
                chk("rnd4 dout", 64'(dout4), 64'(q4[0].d));
                chk("rnd4 out_sel", 64'(osel4), 64'(q4[0].s));
                chk("rnd4 sel_err", 64'(err4), 64'(q4[0].e));
            end
            chk("rnd3 out_valid", 64'(ov3), 64'(q3.size() > 0));
            chk("rnd3 in_ready", 64'(ir3), 64'(q3.size() < 2));
            if (q3.size() > 0) begin
                chk("rnd3 dout", 64'(dout3), 64'(q3[0].d));
                chk("rnd3 out_sel", 64'(osel3), 64'(q3[0].s));
                chk("rnd3 sel_err", 64'(err3), 64'(q3[0].e));
            end

            iv4  = ($urandom_range(0, 3) != 0);
            or4  = ($urandom_range(0, 2) != 0);
            fl4  = ($urandom_range(0, 63) == 0);
            sel4 = 2'($urandom_range(0, 3));
            din4 = {$urandom, $urandom, $urandom, $urandom};
            iv3  = ($urandom_range(0, 2) != 0);
            or3  = ($urandom_range(0, 3) != 0);
            fl3  = ($urandom_range(0, 63) == 0);
            sel3 = 2'($urandom_range(0, 3));
            din3 = {$urandom, $urandom, $urandom};

            begin
                bit rel, acc;
                beat_t b;
                rel = (q4.size() > 0) && or4;
                acc = iv4 && (q4.size() < 2);
                b = model_beat(din4, int'(sel4), 4);
                if (fl4) q4.delete();
                else begin
                    if (rel) void'(q4.pop_front());
                    if (acc) q4.push_back(b);
                end
                rel = (q3.size() > 0) && or3;
                acc = iv3 && (q3.size() < 2);
                b = model_beat({32'h0, din3}, int'(sel3), 3);
                if (fl3) q3.delete();
                else begin
                    if (rel) void'(q3.pop_front());
                    if (acc) q3.push_back(b);
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muxn_skid.md
Name: muxn_skid

Overview:
- Parametrised N-way selector with a registered output and a valid/ready handshake.
- Selects one of N packed input channels, registers the result, and presents it downstream.
- A 2-entry skid buffer sustains full throughput under backpressure.
- Sits between pipeline stages (operand/forwarding select into EX, writeback select) wherever a mux output must be pipelined with stall and flush support.

Parameters:
- WIDTH, 32, data width of each channel.
- N, 4, number of input channels (2..16).
- SW, $clog2(N) (min 1), width of the select field.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  upstream has a select/data beat.
- in_ready  output  1  block can accept a beat this cycle.
- sel  input  SW  channel index; sampled with the beat.
- din  input  N*WIDTH  packed channels; channel k = din[k*WIDTH +: WIDTH].
- out_valid  output  1  dout holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- dout  output  WIDTH  selected, registered data.
- out_sel  output  SW  select index that produced dout.
- sel_err  output  1  the beat on dout had sel >= N.

Behaviour:
- Accept = in_valid & in_ready. Release = out_valid & out_ready.
- Selection at accept time:
  - sel < N: value = channel[sel].
  - sel >= N (only possible when N is not a power of 2): value = 0, and the beat carries err = 1.
- Storage:
  - main register: data, sel, err, valid.
  - skid register: data, sel, err, valid.
  - dout/out_sel/sel_err/out_valid are driven directly from the main register.
- in_ready = ~skid_valid. This is registered state only, with no combinational path from out_ready.
- Latency: a beat accepted in cycle t is visible on dout in cycle t+1 when the main register is empty or releasing.
- Next-state rules, each cycle (flush and rst excluded):
  - main empty or releasing, skid empty: accept loads main; otherwise main_valid <= 0 if released.
  - main empty or releasing, skid full: skid moves to main, skid_valid <= 0. in_ready is 0, so no accept occurs.
  - main full and not releasing, accept: beat loads skid, skid_valid <= 1.
  - main full and not releasing, no accept: hold.
- Stability: while out_valid & ~out_ready, dout/out_sel/sel_err stay constant.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated.
- Throughput: one beat per cycle while out_ready = 1.
- Flush:
  - Next edge clears main_valid and skid_valid.
  - Flush has priority over a same-cycle accept; that beat is discarded. Upstream sees in_ready = 1, so the handshake completes and the beat is lost by design.
  - A same-cycle release is still a valid transfer downstream.
  - Data registers need not be cleared.
- Reset (rst = 1, async):
  - all valid flags, data, sel and err registers go to 0.
  - out_valid = 0, dout = 0, out_sel = 0, sel_err = 0, in_ready = 1.
  - Beats presented while rst is high are ignored.
  - Reset mid-transfer loses both buffered beats.
- Width rules: N = 2 gives SW = 1. Out-of-range detection is compiled out when N is a power of 2.

Decomposition:
- Define.v gets the select-error data constant (`MUXN_ERR_DATA = 0`) and the N range limits.
- Channel mapping to sel values is documented beside the user's select `define`s, as for the existing mux selects.
- One natural combinational sub-module: muxn.
  - Parameters: WIDTH, N, SW.
  - Ports: packed din, sel, out, err.
  - Instantiated once at the input of muxn_skid and reusable standalone in place of chained 2/3-way muxes.

Test Plan:
- Reset: assert rst async mid-cycle with main and skid full → out_valid = 0, dout = 0, in_ready = 1 immediately; after release, first beat (sel = 2, ch2 = 0xA5A5_0002) appears one cycle after accept.
- Streaming: N = 4, out_ready = 1, sel sequence 0,1,2,3 with chk = 0x1000 + k over 4 cycles → dout 0x1000..0x1003 in consecutive cycles, out_sel 0..3, no bubbles.
- Backpressure: out_ready = 0 for 3 cycles while sending sel = 1, then 3 → main holds ch1, skid holds ch3, in_ready = 0; raise out_ready → ch1 then ch3 released in order, in_ready returns to 1.
- Out-of-range: N = 3, sel = 3 → dout = 0, sel_err = 1, out_sel = 3; next beat sel = 0 → sel_err = 0.
- Flush: main and skid full, flush with in_valid = 1 and out_ready = 1 → the main beat transfers that cycle; next cycle out_valid = 0, in_ready = 1, and the incoming beat never appears.
- Random: random in_valid/out_ready/sel for 10k cycles against a queue scoreboard → no loss, duplication or reordering; dout stable under stall.
